scene_sequencer: RTL
====================

# scene_sequencer

Parametrised scene selector for the VGA game path. It picks one of NUM_SCENES pixel-generator outputs and advances to the next scene when the active generator signals completion or a skip is requested. Scene switches are frame-aligned, with an optional run of black frames between scenes. The selected colour is registered on the pixel tick, and the block drives the VGA DAC `rgb` directly, sitting between the pixel generators and the port.

## Interface
- NUM_SCENES, 2: number of pixel sources, ≥2.
- RGB_W, 12: colour width per source.
- BLANK_FRAMES, 1: whole black frames inserted between scenes, 0..255.
- WRAP, 0: 1 = after last scene return to scene 0; 0 = last scene is terminal.

- clk_100MHz  in  1  system clock.
- reset  in  1  synchronous, active-high, debounced.
- p_tick  in  1  pixel enable, one clk wide.
- video_on  in  1  visible-area flag.
- frame_start  in  1  one-clk pulse at start of each frame (x=0, y=0).
- scene_rgb  in  NUM_SCENES*RGB_W  packed source colours; scene k at bits [k*RGB_W +: RGB_W].
- scene_done  in  NUM_SCENES  per-scene completion flag; level or pulse.
- skip  in  1  one-clk advance request.
- rgb  out  RGB_W  registered colour to DAC.
- scene_idx  out  IDX_W = max(1, clog2(NUM_SCENES))  current scene number.
- scene_start  out  NUM_SCENES  one-hot, one-clk pulse when a scene is entered.
- in_transition  out  1  high in PENDING and BLANK.

## Operation
- FSM states: SHOW, PENDING, BLANK, ENTER.
- **SHOW**
  - Advance request = `scene_done[scene_idx]` OR `skip`, sampled only in SHOW.
  - No advance request when idx is the last scene and WRAP=0; the block stays in SHOW.
  - A valid request moves the FSM to PENDING.
- **PENDING:** on `frame_start`, go to BLANK if BLANK_FRAMES>0 and load blank_cnt = BLANK_FRAMES; otherwise go to ENTER.
- **BLANK:** each `frame_start` decrements blank_cnt. When the decrement takes blank_cnt to 0, go to ENTER.
- **ENTER:** one clk.
  - scene_idx ← idx+1, or 0 on wrap.
  - `scene_start[new idx]` pulses.
  - Next state is SHOW.
- scene_idx changes only in ENTER.
- `scene_done` and `skip` are ignored outside SHOW.
- `done` and `skip` in the same clk produce one advance only.
- `frame_start` coinciding with an advance request in SHOW does not switch in that frame. The switch happens at the next `frame_start`.
- **RGB register** (updates only when `p_tick`=1):
  - rgb ← 0 if `video_on`=0 or the state is BLANK.
  - Otherwise rgb ← `scene_rgb` slice[scene_idx].
  - The register holds between ticks.
- **Arithmetic:**
  - Index compare is against NUM_SCENES-1 at IDX_W bits.
  - blank_cnt width is clog2(BLANK_FRAMES+1), minimum 1 bit.
  - No out-of-range slice is ever selected.

## Timing
- **Reset values** (from the first clk edge with reset=1):
  - state=SHOW, scene_idx=0, blank_cnt=0.
  - rgb=0, scene_start=0, in_transition=0.
- **Reset mid-transition:** abandon the transition immediately; no `scene_start` pulse is issued.
- **rgb latency:** `rgb` reflects inputs sampled on the `p_tick` clk, visible the following clk.
- **Request to PENDING:** 1 clk.
- **Scene change after the request:**
  - BLANK_FRAMES=0: PENDING→ENTER on the `frame_start` clk; new scene_idx at the next clk edge after ENTER (2 clks after `frame_start`).
  - BLANK_FRAMES=N: the new scene begins N `frame_start` pulses after the first one.
- **Timing of in_transition:** asserted from the clk after the request through the ENTER clk exclusive.
- **scene_start:** exactly 1 clk, coincident with the clk in which scene_idx first shows the new value.

## Structure
- **Shared `video_pkg`:**
  - RGB_W default.
  - COLOR_BLACK constant.
  - scene_state_t enum {SHOW, PENDING, BLANK, ENTER}.
  - IDX_W helper function.
- **Sub-module `scene_rgb_mux`:** combinational indexed slice select plus blank/video_on forcing. The FSM, counters and the rgb register stay in scene_sequencer.
- Integration: replaces the two-source state/mux logic in the top level.

## Test plan
- **Reset hold:** reset for 3 clks with random scene_rgb → rgb=0, scene_idx=0, scene_start=0, in_transition=0.
- **Basic switch:** NUM_SCENES=3, BLANK_FRAMES=0, `scene_done[0]`=1 mid-frame → scene_idx=1 two clks after the next `frame_start`; `scene_start`=3'b010 for 1 clk; rgb then tracks scene 1 (drive 12'hF00 on scene 1 → rgb=12'hF00).
- **Blank frames:** BLANK_FRAMES=2, `skip` pulse → rgb=0 for exactly 2 full frames, then scene 1 colours; in_transition high throughout.
- **Terminal vs wrap:** at scene 2 of 3, `done`:
  - WRAP=0 → scene_idx stays 2 indefinitely, no pulse.
  - WRAP=1 → scene_idx=0 and `scene_start`=3'b001.
- **Simultaneous and ignored inputs:**
  - `done`+`skip`+`frame_start` in one clk → single advance, taken at the following `frame_start`.
  - `done` asserted during BLANK → ignored.
- **Reset mid-BLANK and video_on:**
  - reset mid-BLANK → scene_idx=0, no `scene_start`.
  - video_on=0 with scene rgb 12'hFFF → rgb=0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared VGA video-path types, constants and helpers.
package video_pkg;

  localparam int unsigned RGB_W_DEFAULT = 12;
  localparam logic [RGB_W_DEFAULT-1:0] COLOR_BLACK = '0;

  typedef enum logic [1:0] {
    SHOW    = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2,
    ENTER   = 2'd3
  } scene_state_t;

  // Scene index width: at least one bit even for a single source.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/scene_rgb_mux.sv
// Selects the active scene colour, forcing black outside the visible area or while blanking.
module scene_rgb_mux
  import video_pkg::*;
#(
  parameter int unsigned NUM_SCENES = 2,
  parameter int unsigned RGB_W      = RGB_W_DEFAULT,
  localparam int unsigned IDX_W     = idx_w(NUM_SCENES)
) (
  input  logic [NUM_SCENES*RGB_W-1:0] scene_rgb,
  input  logic [IDX_W-1:0]            scene_idx,
  input  logic                        video_on,
  input  logic                        blank,
  output logic [RGB_W-1:0]            rgb_c
);

  // Compare-based select so an index past the last scene can never slice out of range.
  always_comb begin
    rgb_c = RGB_W'(COLOR_BLACK);
    if (video_on && !blank) begin
      for (int unsigned k = 0; k < NUM_SCENES; k++) begin
        if (scene_idx == IDX_W'(k)) begin
          rgb_c = scene_rgb[k*RGB_W +: RGB_W];
        end
      end
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// Frame-aligned scene selector: advances on scene completion or skip, with optional black frames.
module scene_sequencer
  import video_pkg::*;
#(
  parameter int unsigned NUM_SCENES   = 2,
  parameter int unsigned RGB_W        = RGB_W_DEFAULT,
  parameter int unsigned BLANK_FRAMES = 1,
  parameter bit          WRAP         = 1'b0,
  localparam int unsigned IDX_W       = idx_w(NUM_SCENES)
) (
  input  logic                        clk_100MHz,
  input  logic                        reset,
  input  logic                        p_tick,
  input  logic                        video_on,
  input  logic                        frame_start,
  input  logic [NUM_SCENES*RGB_W-1:0] scene_rgb,
  input  logic [NUM_SCENES-1:0]       scene_done,
  input  logic                        skip,
  output logic [RGB_W-1:0]            rgb,
  output logic [IDX_W-1:0]            scene_idx,
  output logic [NUM_SCENES-1:0]       scene_start,
  output logic                        in_transition
);

  localparam int unsigned CNT_W =
    (BLANK_FRAMES > 32'd0) ? 32'($clog2(BLANK_FRAMES + 32'd1)) : 32'd1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SCENES - 32'd1);

  scene_state_t      state;
  logic [CNT_W-1:0]  blank_cnt;
  logic              done_sel_c;
  logic              is_last_c;
  logic              adv_req_c;
  logic [IDX_W-1:0]  next_idx_c;
  logic [RGB_W-1:0]  mux_rgb_c;

  // Completion flag of the scene currently shown.
  always_comb begin
    done_sel_c = 1'b0;
    for (int unsigned k = 0; k < NUM_SCENES; k++) begin
      if (scene_idx == IDX_W'(k)) begin
        done_sel_c = scene_done[k];
      end
    end
  end

  assign is_last_c  = (scene_idx == LAST_IDX);
  assign adv_req_c  = (done_sel_c | skip) & (WRAP | ~is_last_c);
  assign next_idx_c = is_last_c ? '0 : scene_idx + IDX_W'(1);

  // Scene FSM: request -> wait for frame boundary -> optional blank frames -> enter next scene.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state         <= SHOW;
      scene_idx     <= '0;
      blank_cnt     <= '0;
      scene_start   <= '0;
      in_transition <= 1'b0;
    end else begin
      scene_start <= '0;
      case (state)
        SHOW: begin
          if (adv_req_c) begin
            state         <= PENDING;
            in_transition <= 1'b1;
          end
        end
        PENDING: begin
          if (frame_start) begin
            if (BLANK_FRAMES > 32'd0) begin
              state     <= BLANK;
              blank_cnt <= CNT_W'(BLANK_FRAMES);
            end else begin
              state         <= ENTER;
              in_transition <= 1'b0;
            end
          end
        end
        BLANK: begin
          if (frame_start) begin
            blank_cnt <= blank_cnt - CNT_W'(1);
            if (blank_cnt == CNT_W'(1)) begin
              state         <= ENTER;
              in_transition <= 1'b0;
            end
          end
        end
        ENTER: begin
          scene_idx   <= next_idx_c;
          scene_start <= NUM_SCENES'(1) << next_idx_c;
          state       <= SHOW;
        end
        default: begin
          state         <= SHOW;
          in_transition <= 1'b0;
        end
      endcase
    end
  end

  scene_rgb_mux #(
    .NUM_SCENES (NUM_SCENES),
    .RGB_W      (RGB_W)
  ) u_mux (
    .scene_rgb (scene_rgb),
    .scene_idx (scene_idx),
    .video_on  (video_on),
    .blank     (state == BLANK),
    .rgb_c     (mux_rgb_c)
  );

  // DAC colour register, updated only on pixel ticks.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rgb <= RGB_W'(COLOR_BLACK);
    end else if (p_tick) begin
      rgb <= mux_rgb_c;
    end
  end

endmodule
